puzzle_move_ctrl: RTL
=====================

Name: puzzle_move_ctrl

Overview:
Move sequencer for the 2x3 five-puzzle. It is the initiator side of the 16x40 register-file port: it drives src0/src1/dst/we/data and consumes data0/data1. On each accepted move command it:
- reads the board (r0), move count (r1) and move order (r2),
- slides the blank tile,
- writes back the new board, count+1 and the appended order.
It flags illegal moves and reports when the board reaches the goal.

Parameters:
W, 40, register-file data width
BOARD_REG, 0, register index holding the board
CNT_REG, 1, register index holding the move count
ORD_REG, 2, register index holding the move history
GOAL, 18'b001010011100101000, solved board (tiles 1,2,3,4,5,blank)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  move command valid
cmd_dir  in  2  blank direction: 00 up, 01 down, 10 left, 11 right
cmd_ready  out  1  controller can accept a command
src0  out  4  register-file read address 0
src1  out  4  register-file read address 1
data0  in  W  read data for src0 (combinational read)
data1  in  W  read data for src1 (combinational read)
dst  out  4  register-file write address
we  out  1  register-file write enable
data  out  W  register-file write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of every command
illegal  out  1  qualifies done: move rejected, no writes made
solved  out  1  qualifies done: new board equals GOAL

Behaviour:
- Board format: six 3-bit cells in bits [17:0]. Cell 0 = [17:15] … cell 5 = [2:0]. Row-major: cells 0-2 are the top row, 3-5 the bottom row. Value 0 = blank. Bits [W-1:18] are written as 0.
- States: IDLE, RD0, RD1, CALC, WR_B, WR_C, WR_O, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_dir and go to RD0.
- RD0:
  - src0=BOARD_REG, src1=CNT_REG.
  - Register data0[17:0] as the board and data1 as the count.
  - Go to RD1.
- RD1: src1=ORD_REG; register data1 as the order; go to CALC.
- CALC:
  - Locate the blank at the lowest cell index holding 0.
  - Illegal if any of these holds:
    - no blank is found;
    - up from the top row;
    - down from the bottom row;
    - left from column 0;
    - right from column 2.
  - Neighbour index: up -3, down +3, left -1, right +1. Swap the blank with the neighbour.
  - New count = count+1 mod 2^W.
  - New order = {order[W-3:0], dir}, i.e. a left shift by 2 with dir inserted in bits [1:0].
  - Illegal → DONE with illegal latched. Legal → WR_B.
- Write states, one cycle each, we=1 for exactly that cycle:
  - WR_B: dst=BOARD_REG, data=new board.
  - WR_C: dst=CNT_REG, data=new count.
  - WR_O: dst=ORD_REG, data=new order.
  - WR_O → DONE.
- DONE:
  - done=1 for one cycle.
  - illegal and solved are valid only in this cycle; solved = legal && new board==GOAL.
  - Go to IDLE.
- Latency: handshake in cycle 0, writes in cycles 4/5/6, done in cycle 7. An illegal move gives done in cycle 4. Throughput is one command per 8 cycles.
- Outside the write states: we=0, dst=0, data=0.
- Outside RD0/RD1: src0=BOARD_REG, src1=CNT_REG.
- cmd_dir is ignored after acceptance. cmd_valid during busy is not accepted (cmd_ready=0).
- Reset (asynchronous, any state):
  - state=IDLE;
  - we=0, done=0, illegal=0, solved=0, busy=0;
  - cmd_ready=1 once reset is released;
  - all latched values cleared.
- Reset mid-command abandons it. Partial writes already made stay in the register file unless the file is reset too (it shares rst_n and resets synchronously).
- Write data is driven from registers, not combinationally from data0/data1.

Decomposition:
- puzzle_pkg contains:
  - dir encoding constants (DIR_UP/DOWN/LEFT/RIGHT);
  - CELL_W=3, NCELL=6, COLS=3;
  - register indices BOARD_REG/CNT_REG/ORD_REG;
  - GOAL and the reset board 18'b001011101100010000;
  - state encoding.
- Sub-module puzzle_move_calc: combinational blank locate, legality check and swap. Inputs are board and dir; outputs are new_board and illegal. It is instantiated once, in CALC.

Test Plan:
1. Reset board 001011101100010000 (1,3,5,4,2,0), cnt=0, ord=0. Command dir=00 (up):
   - writes r0=18'b001011000100010101 (1,3,0,4,2,5), r1=1, r2=0;
   - done in cycle 7 with illegal=0, solved=0.
2. Same start, dir=10 (left): r0=18'b001011101100000010, r1=1, r2=2'b10.
3. Same start, dir=01 (down), then dir=11 (right):
   - each gives done with illegal=1 in cycle 4;
   - we never asserted; r0/r1/r2 unchanged.
4. Preload r0 = 1,2,3,4,0,5 (001010011100000101), r1=7, r2=40'h3. Command dir=11: r0=GOAL, r1=8, r2=40'hF, done with solved=1.
5. Preload r1=40'hFFFFFFFFFF and issue a legal move:
   - count wraps to r1=0;
   - r2 top bits shift out.
6. Hold cmd_valid high through a command with cmd_dir changing every cycle:
   - only one command per 8 cycles is accepted;
   - each uses the dir sampled at acceptance.
   Assert rst_n=0 during WR_C: we drops immediately, state returns to IDLE, cmd_ready=1 after release.

Source files
------------

// File: rtl/puzzle_pkg.sv
// puzzle_pkg: board geometry, direction/state encodings and register map
// shared by the five-puzzle move sequencer and its move calculator.
package puzzle_pkg;
   localparam int CELL_W = 3;
   localparam int NCELL  = 6;
   localparam int COLS   = 3;
   localparam int BW     = CELL_W * NCELL;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   localparam logic [3:0] BOARD_REG = 4'd0;
   localparam logic [3:0] CNT_REG   = 4'd1;
   localparam logic [3:0] ORD_REG   = 4'd2;

   localparam logic [BW-1:0] GOAL        = 18'b001010011100101000;
   localparam logic [BW-1:0] RESET_BOARD = 18'b001011101100010000;

   typedef enum logic [2:0] {
      S_IDLE, S_RD0, S_RD1, S_CALC, S_WR_B, S_WR_C, S_WR_O, S_DONE
   } state_e;

   // Cell 0 sits in the most significant field of the board word.
   function automatic logic [CELL_W-1:0] cell_at(input logic [BW-1:0] b, input int i);
      return b[(NCELL-1-i)*CELL_W +: CELL_W];
   endfunction
endpackage

// File: rtl/puzzle_move_ctrl_if.sv
// puzzle_move_ctrl_if: command handshake, register-file port and status
// signals of the move sequencer; master is the sequencer side.
interface puzzle_move_ctrl_if #(parameter int W = 40);
   logic         cmd_valid;
   logic [1:0]   cmd_dir;
   logic         cmd_ready;
   logic [3:0]   src0, src1, dst;
   logic [W-1:0] data0, data1, data;
   logic         we, busy, done, illegal, solved;

   modport master (
      input  cmd_valid, cmd_dir, data0, data1,
      output cmd_ready, src0, src1, dst, we, data, busy, done, illegal, solved
   );
   modport slave (
      output cmd_valid, cmd_dir, data0, data1,
      input  cmd_ready, src0, src1, dst, we, data, busy, done, illegal, solved
   );
endinterface

// File: rtl/puzzle_move_calc.sv
// puzzle_move_calc: finds the blank (lowest empty cell), checks the move
// against the 2x3 edges and returns the board with blank and neighbour swapped.
module puzzle_move_calc
   import puzzle_pkg::*;
(
   input  logic [BW-1:0] board_i,
   input  logic [1:0]    dir_i,
   output logic [BW-1:0] new_board_o,
   output logic          illegal_o
);
   logic [2:0]        blank, nb;
   logic              found, bottom;
   logic [1:0]        col;
   logic [CELL_W-1:0] nb_val;
   logic [BW-1:0]     swapped;

   // Scan high to low so the last hit is the lowest blank index.
   always_comb begin
      blank = '0;
      found = 1'b0;
      for (int i = NCELL-1; i >= 0; i--)
         if (cell_at(board_i, i) == '0) begin
            blank = 3'(i);
            found = 1'b1;
         end
   end

   assign bottom = blank >= 3'(COLS);
   assign col    = 2'(bottom ? blank - 3'(COLS) : blank);

   assign illegal_o = !found
                   || (dir_i == DIR_UP    && !bottom)
                   || (dir_i == DIR_DOWN  &&  bottom)
                   || (dir_i == DIR_LEFT  && col == 2'd0)
                   || (dir_i == DIR_RIGHT && col == 2'(COLS-1));

   assign nb = dir_i == DIR_UP   ? blank - 3'(COLS) :
               dir_i == DIR_DOWN ? blank + 3'(COLS) :
               dir_i == DIR_LEFT ? blank - 3'd1 : blank + 3'd1;

   always_comb begin
      nb_val = '0;
      for (int i = 0; i < NCELL; i++)
         if (3'(i) == nb) nb_val = cell_at(board_i, i);
   end

   always_comb begin
      swapped = board_i;
      for (int i = 0; i < NCELL; i++)
         swapped[(NCELL-1-i)*CELL_W +: CELL_W] = 3'(i) == blank ? nb_val :
                                                 3'(i) == nb    ? '0 : cell_at(board_i, i);
   end

   assign new_board_o = illegal_o ? board_i : swapped;
endmodule

// File: rtl/puzzle_move_ctrl.sv
// puzzle_move_ctrl: per command reads board/count/order from the register
// file, slides the blank, writes the three registers back and reports status.
module puzzle_move_ctrl
   import puzzle_pkg::*;
#(
   parameter int W = 40
)(
   input  logic clk,
   input  logic rst_n,
   puzzle_move_ctrl_if.master mv
);
   state_e        state_q, state_d;
   logic [1:0]    dir_q, dir_d;
   logic [BW-1:0] board_q, board_d, new_board;
   logic [W-1:0]  cnt_q, cnt_d, ord_q, ord_d;
   logic          ill_q, ill_d, sol_q, sol_d, calc_ill;
   logic          unused_data0;

   assign unused_data0 = ^mv.data0[W-1:BW];

   puzzle_move_calc u_calc (
      .board_i     (board_q),
      .dir_i       (dir_q),
      .new_board_o (new_board),
      .illegal_o   (calc_ill)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         dir_q   <= '0;
         board_q <= '0;
         cnt_q   <= '0;
         ord_q   <= '0;
         ill_q   <= 1'b0;
         sol_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         board_q <= board_d;
         cnt_q   <= cnt_d;
         ord_q   <= ord_d;
         ill_q   <= ill_d;
         sol_q   <= sol_d;
      end

   // CALC overwrites the read values with the results, so the write states
   // drive registered data only.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      board_d = board_q;
      cnt_d   = cnt_q;
      ord_d   = ord_q;
      ill_d   = ill_q;
      sol_d   = sol_q;
      case (state_q)
         S_IDLE: if (mv.cmd_valid) begin
            dir_d   = mv.cmd_dir;
            state_d = S_RD0;
         end
         S_RD0: begin
            board_d = mv.data0[BW-1:0];
            cnt_d   = mv.data1;
            state_d = S_RD1;
         end
         S_RD1: begin
            ord_d   = mv.data1;
            state_d = S_CALC;
         end
         S_CALC: begin
            board_d = new_board;
            cnt_d   = cnt_q + W'(1);
            ord_d   = {ord_q[W-3:0], dir_q};
            ill_d   = calc_ill;
            sol_d   = !calc_ill && new_board == GOAL;
            state_d = calc_ill ? S_DONE : S_WR_B;
         end
         S_WR_B:  state_d = S_WR_C;
         S_WR_C:  state_d = S_WR_O;
         S_WR_O:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   assign mv.cmd_ready = state_q == S_IDLE;
   assign mv.busy      = state_q != S_IDLE;
   assign mv.done      = state_q == S_DONE;
   assign mv.illegal   = mv.done && ill_q;
   assign mv.solved    = mv.done && sol_q;
   assign mv.src0      = BOARD_REG;
   assign mv.src1      = state_q == S_RD1 ? ORD_REG : CNT_REG;
   assign mv.we        = state_q inside {S_WR_B, S_WR_C, S_WR_O};
   assign mv.dst       = state_q == S_WR_B ? BOARD_REG :
                         state_q == S_WR_C ? CNT_REG   :
                         state_q == S_WR_O ? ORD_REG   : '0;
   assign mv.data      = state_q == S_WR_B ? W'(board_q) :
                         state_q == S_WR_C ? cnt_q       :
                         state_q == S_WR_O ? ord_q       : '0;
endmodule
